// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_pkg;

  // Number of mux channels scanned per frame.
  localparam int N_CH    = 4;
  // Width of the mux select bus.
  localparam int SEL_W   = 2;
  // Width of an assembled frame: one sampled bit per channel.
  localparam int FRAME_W = 4;

  // Sequencer states: waiting for start, or stepping through channels.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage : mux_scan_pkg

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell timer: counts the cycles a mux channel has been selected and flags
// the final cycle of the dwell so the caller can sample and advance.
module mux_scan_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  // Count up while enabled, wrapping to 0 after the last dwell cycle; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST_VAL) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule : mux_scan_dwell_cnt

// File: rtl/mux_scan_ctrl.sv
// Upstream sequencer for the 4:1 mux: steps sel through channels 0..3,
// holding each for DWELL cycles, samples y on the last dwell cycle and
// hands the assembled 4-bit frame downstream.
//
// Downstream handshake: a frame transfers on any rising edge where
// frame_valid && frame_ready. While frame_valid is high and frame_ready is
// low, frame_data is held stable. A frame completing while the output
// register is occupied and not being accepted is dropped (overrun pulse);
// a frame completing in the same cycle as an accept replaces it seamlessly.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               continuous,
  output logic [SEL_W-1:0]   sel,
  input  logic               y_in,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               busy,
  output logic               overrun,
  output state_t             dbg_state
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t           state;
  logic [SEL_W-1:0] ch;
  logic [N_CH-2:0]  shadow;
  logic             dwell_last;
  logic             dwell_clear;
  logic             dwell_en;
  logic             out_free;

  // The dwell timer runs only while scanning and is parked at 0 in IDLE,
  // so a new scan always starts with a full dwell on channel 0.
  assign dwell_clear = (state == IDLE);
  assign dwell_en    = (state == SCAN);

  mux_scan_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (dwell_clear),
    .enable (dwell_en),
    .last   (dwell_last)
  );

  // The output register can take a new frame if it is empty or being drained now.
  always_comb begin
    out_free = !frame_valid || frame_ready;
  end

  // Scan FSM with channel counter, sample shadow and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      shadow      <= '0;
      sel         <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // Accept drains the output register; a completion below may refill it.
      if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            ch    <= '0;
            sel   <= '0;
            busy  <= 1'b1;
          end
        end

        SCAN: begin
          if (dwell_last) begin
            if (ch != LAST_CH) begin
              // Only the value on the final dwell cycle is kept.
              for (int i = 0; i < N_CH - 1; i++) begin
                if (ch == SEL_W'(i)) begin
                  shadow[i] <= y_in;
                end
              end
              ch  <= ch + 1'b1;
              sel <= ch + 1'b1;
            end else begin
              // Last channel: the frame completes with y_in as its top bit.
              ch  <= '0;
              sel <= '0;
              if (out_free) begin
                frame_data  <= {y_in, shadow};
                frame_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              if (!continuous) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          ch    <= '0;
          sel   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule : mux_scan_ctrl

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scenarios plus a
// randomized run, all checked against a frame-level reference model.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int DWELL = 4;
  localparam int FRAME_CYC = N_CH * DWELL;

  // Clock / reset and DUT connections.
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         frame_ready = 1'b0;
  logic [1:0]   sel;
  logic         y_in;
  logic [3:0]   frame_data;
  logic         frame_valid;
  logic         busy;
  logic         overrun;
  state_t       dbg_state;
  logic [3:0]   mux_d = 4'b0000;

  always #5 clk = ~clk;

  // Behavioural 4:1 mux feeding the sequencer: input i drives y when sel == i.
  assign y_in = mux_d[sel];

  mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .sel         (sel),
    .y_in        (y_in),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // Scoreboard counters.
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a scan is a window of FRAME_CYC cycles indexed by m_k;
  // channel = m_k / DWELL, sample when m_k is the last cycle of a dwell.
  bit         m_scan;
  int         m_k;
  logic [3:0] m_bits;
  logic [3:0] m_fd;
  logic       m_fv;
  logic       m_ovr;
  logic       m_busy;
  logic [1:0] m_sel;

  task automatic model_reset();
    m_scan = 0;
    m_k    = 0;
    m_bits = '0;
    m_fd   = '0;
    m_fv   = 0;
    m_ovr  = 0;
    m_busy = 0;
    m_sel  = '0;
  endtask

  task automatic model_edge();
    logic y;
    bit   done;
    y    = mux_d[m_sel];
    done = 0;
    if (!m_scan) begin
      if (start) begin
        m_scan = 1;
        m_k    = 0;
      end
    end else begin
      if (m_k % DWELL == DWELL - 1) m_bits[m_k / DWELL] = y;
      if (m_k == FRAME_CYC - 1) begin
        done   = 1;
        m_k    = 0;
        m_scan = continuous;
      end else begin
        m_k++;
      end
    end
    m_ovr = 0;
    if (done) begin
      if (!m_fv || frame_ready) begin
        m_fd = m_bits;
        m_fv = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_fv && frame_ready) begin
      m_fv = 0;
    end
    m_busy = m_scan;
    m_sel  = m_scan ? 2'(m_k / DWELL) : 2'd0;
  endtask

  task automatic check_outputs();
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_busy));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("frame_data", 32'(frame_data), 32'(m_fd));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("state", 32'(dbg_state), m_scan ? 32'(SCAN) : 32'(IDLE));
  endtask

  // Driver: one clock; inputs are set beforehand, outputs checked 1ns after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_fd"}, 32'(frame_data), 32'd0);
    check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  // Asynchronous reset pulse from the mid-cycle phase; outputs must clear at once.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  // Bring the DUT back to IDLE with an empty output register, bounded.
  task automatic drain();
    start       = 1'b0;
    continuous  = 1'b0;
    frame_ready = 1'b1;
    for (int i = 0; i < 100 && (busy || frame_valid); i++) step();
    check("drain_idle", 32'({busy, frame_valid}), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single scan, a=1 b=0 c=1 d=0.
    drain();
    mux_d = 4'b0101; continuous = 1'b0; frame_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= FRAME_CYC + 1; i++) begin
      step();
      if (i % DWELL == 0 && i < FRAME_CYC) check("t2_sel_step", 32'(sel), 32'(i / DWELL));
      if (i == FRAME_CYC) begin
        check("t2_fv", 32'(frame_valid), 32'd1);
        check("t2_fd", 32'(frame_data), 32'h5);
      end
      if (i == FRAME_CYC + 1) begin
        check("t2_fv_drop", 32'(frame_valid), 32'd0);
        check("t2_busy_done", 32'(busy), 32'd0);
      end
    end

    // Reset at cycle 7 of a scan, then no activity until start.
    drain();
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    reset_pulse("t1_midscan");
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_busy_idle", 32'(busy), 32'd0);
    end

    // Backpressure with overrun on the second completion.
    drain();
    continuous = 1'b1; frame_ready = 1'b0; mux_d = 4'b1111;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 2 * FRAME_CYC + 1; i++) begin
      if (i == FRAME_CYC + 1) mux_d = 4'b0111;
      step();
      if (i == FRAME_CYC) check("t3_first_fd", 32'(frame_data), 32'hF);
      if (i == 2 * FRAME_CYC) begin
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_fd_kept", 32'(frame_data), 32'hF);
      end
      if (i == 2 * FRAME_CYC + 1) check("t3_overrun_1cyc", 32'(overrun), 32'd0);
    end
    frame_ready = 1'b1;
    check("t3_offer_fd", 32'(frame_data), 32'hF);
    step();
    check("t3_accepted", 32'(frame_valid), 32'd0);

    // Accept exactly on the second completion cycle.
    drain();
    continuous = 1'b1; frame_ready = 1'b0; mux_d = 4'b1010;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 2 * FRAME_CYC; i++) begin
      if (i == FRAME_CYC + 1) mux_d = 4'b0110;
      frame_ready = (i == 2 * FRAME_CYC);
      step();
      if (i == FRAME_CYC) check("t4_first_fd", 32'(frame_data), 32'hA);
    end
    check("t4_fv_stays", 32'(frame_valid), 32'd1);
    check("t4_no_ovr", 32'(overrun), 32'd0);
    check("t4_new_fd", 32'(frame_data), 32'h6);
    frame_ready = 1'b0;
    step();

    // Start ignored mid-scan; continuous dropped at cycle 20.
    drain();
    continuous = 1'b1; frame_ready = 1'b1; mux_d = 4'($urandom_range(0, 15));
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 2 * FRAME_CYC; i++) begin
      start = (i == 5);
      if (i == 20) continuous = 1'b0;
      step();
      if (i == FRAME_CYC - 1) check("t5_no_early_frame", 32'(frame_valid), 32'd0);
      if (i == FRAME_CYC) check("t5_frame1", 32'(frame_valid), 32'd1);
    end
    start = 1'b0;
    check("t5_frame2", 32'(frame_valid), 32'd1);
    check("t5_idle", 32'(busy), 32'd0);

    // Glitching b during channel 1 dwell; only the final dwell cycle counts.
    drain();
    mux_d = 4'b0000;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= FRAME_CYC; i++) begin
      case (i)
        5:       mux_d[1] = 1'b0;
        6:       mux_d[1] = 1'b1;
        7:       mux_d[1] = 1'b0;
        8:       mux_d[1] = 1'b1;
        default: mux_d[1] = (i > 8 && i % 2 == 1);
      endcase
      step();
    end
    check("t6_bit1", 32'(frame_data[1]), 32'd1);
    check("t6_fd", 32'(frame_data), 32'h2);

    // Randomized run with occasional asynchronous resets.
    drain();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) continuous = ~continuous;
      frame_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      mux_d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) reset_pulse("rnd_reset");
      else step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_scan_ctrl
